moving_avg_reader: RTL and testbench
====================================

Name: moving_avg_reader

Overview:
- Consumer end of the DDS tap delay line: reads the newest sample plus the delayed taps (1/8/16/32/64/128/256) and produces a running moving average over a selectable power-of-two window.
- Recursive running sum: acc <= acc + x_in - x_delayed_N, then an arithmetic right shift by log2(N).
- Sits directly downstream of the delay line and shares its sample strobe.

Parameters:
- SIG_WIDTH, 16, signed sample width of x_in, the taps and y_out.
- ACC_WIDTH, SIG_WIDTH+9, accumulator width: 8 bits of growth for N=256 plus 1 guard bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sample strobe; the same strobe that shifts the delay line
- win_sel  in  3  window select: 0=1, 1=8, 2=16, 3=32, 4=64, 5=128, 6=256; 7 is reserved and treated as 1
- x_in  in  SIG_WIDTH  newest sample, signed; the same value written into the delay line this strobe
- tap_1, tap_8, tap_16, tap_32, tap_64, tap_128, tap_256  in  SIG_WIDTH each  delay-line taps; tap_N = sample from N strobes ago, valid in the cycle where en=1
- y_out  out  SIG_WIDTH  averaged sample, signed
- y_valid  out  1  one-cycle pulse; y_out is new this cycle
- filled  out  1  high while in RUN (window fully populated)

Behaviour:
- Reset (rst_n=0, asynchronous): acc=0, y_out=0, y_valid=0, filled=0, fill_cnt=0, sel_q=0, state=FILL.
- sel_q is the registered window in use. A change is detected when en=1 and win_sel != sel_q.
- FILL state:
  - On en: acc <= acc + x_in (no subtract); fill_cnt++.
  - When fill_cnt reaches N-1 on an en, go to RUN the next cycle and set filled=1.
- RUN state:
  - On en: acc <= acc + x_in - tap_N, where tap_N is muxed by sel_q.
  - A mismatched tap (wrong N) is a system error; no detection.
- Window change (en=1, win_sel != sel_q), in either state:
  - That cycle: sel_q <= win_sel; acc <= x_in; fill_cnt <= 1; filled <= 0; state FILL (or RUN immediately if the new N=1).
  - y_valid is still asserted for this sample, computed under the new window with the restarted acc.
- Output:
  - Registered; latency 1 cycle after the en cycle.
  - y_out <= sign-extended (acc_next >>> log2(N)), arithmetic shift, truncated to SIG_WIDTH. No saturation is needed because the average of N samples stays in range.
  - y_valid <= en, in every state, including FILL. During FILL, y_out is the partial sum shifted, i.e. it ramps up.
- N=1: state is always RUN and y_out = x_in registered (acc - tap_1 + x_in with acc = tap_1).
- en low: all state holds; y_valid=0.
- Back-to-back en on every cycle is supported with no stall.
- Reset mid-operation: immediate return to the reset state. The delay line is cleared by its own reset, so the taps read 0 afterwards.

Optional Feature:
- Macro: MOVING_AVG_ROUND_EN.
- Defined: round half-up before the shift: y_out = (acc_next + 2^(log2(N)-1)) >>> log2(N). No rounding for N=1. One extra adder; latency unchanged.
- Undefined: plain arithmetic shift (floor toward -inf).

Decomposition:
- Shared package dsp_pkg:
  - WIN_SEL_* codes 0..6.
  - Function win_log2(sel) returning 0, 3, 4, 5, 6, 7, 8.
  - Function win_len(sel) = 1 << win_log2.
- One natural sub-module, tap_mux: combinational selection of tap_N by sel_q. Everything else (FSM, accumulator, output register) stays in moving_avg_reader.

Test Plan:
- Reset then N=8, constant x_in=100 on 20 strobes with the taps fed from a behavioural delay model:
  - y_out ramps 12, 25, 37, 50, 62, 75, 87, 100 (floor).
  - filled rises after the 8th strobe; y_out stays 100.
- N=256, alternating +1000/-1000 for 600 strobes:
  - After fill, y_out=0 every sample.
  - acc never exceeds ACC_WIDTH range (assertion).
- N=16 steady at x_in=-32767, then win_sel to 2 (N=16) -> 0 (N=1) mid-stream:
  - Switch cycle gives y_out = x_in; filled=1 immediately.
  - No glitch on y_valid.
- en gaps: random en duty of 30% with N=32, random samples:
  - y_out matches the reference model exactly.
  - y_valid count equals en count.
- rst_n asserted asynchronously mid-RUN (between edges):
  - Outputs go to 0 immediately.
  - After release, FILL restarts with fill_cnt=0.
- MOVING_AVG_ROUND_EN build, N=8, x_in=3 constant:
  - Fill output is 0, 1, 1, 2, 2, 2, 3, 3 (rounded) versus 0, 0, 1, 1, 1, 2, 2, 3 without the macro.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared window-select codes and helpers for the moving-average reader.
package dsp_pkg;

  localparam logic [2:0] WIN_SEL_1   = 3'd0;
  localparam logic [2:0] WIN_SEL_8   = 3'd1;
  localparam logic [2:0] WIN_SEL_16  = 3'd2;
  localparam logic [2:0] WIN_SEL_32  = 3'd3;
  localparam logic [2:0] WIN_SEL_64  = 3'd4;
  localparam logic [2:0] WIN_SEL_128 = 3'd5;
  localparam logic [2:0] WIN_SEL_256 = 3'd6;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Reserved code 7 falls into the default and behaves as a window of 1.
  function automatic logic [3:0] win_log2(input logic [2:0] sel);
    case (sel)
      WIN_SEL_1:   win_log2 = 4'd0;
      WIN_SEL_8:   win_log2 = 4'd3;
      WIN_SEL_16:  win_log2 = 4'd4;
      WIN_SEL_32:  win_log2 = 4'd5;
      WIN_SEL_64:  win_log2 = 4'd6;
      WIN_SEL_128: win_log2 = 4'd7;
      WIN_SEL_256: win_log2 = 4'd8;
      default:     win_log2 = 4'd0;
    endcase
  endfunction

  function automatic logic [8:0] win_len(input logic [2:0] sel);
    win_len = 9'd1 << win_log2(sel);
  endfunction

endpackage

// File: rtl/moving_avg_reader_tap_mux.sv
// Selects the delay-line tap matching the active averaging window.
module tap_mux
  import dsp_pkg::*;
#(
  parameter int SIG_WIDTH = 16
) (
  input  logic [2:0]           sel,
  input  logic [SIG_WIDTH-1:0] tap_1,
  input  logic [SIG_WIDTH-1:0] tap_8,
  input  logic [SIG_WIDTH-1:0] tap_16,
  input  logic [SIG_WIDTH-1:0] tap_32,
  input  logic [SIG_WIDTH-1:0] tap_64,
  input  logic [SIG_WIDTH-1:0] tap_128,
  input  logic [SIG_WIDTH-1:0] tap_256,
  output logic [SIG_WIDTH-1:0] tap_sel
);

  // One-of-seven tap selection by window code
  always_comb begin
    case (sel)
      WIN_SEL_1:   tap_sel = tap_1;
      WIN_SEL_8:   tap_sel = tap_8;
      WIN_SEL_16:  tap_sel = tap_16;
      WIN_SEL_32:  tap_sel = tap_32;
      WIN_SEL_64:  tap_sel = tap_64;
      WIN_SEL_128: tap_sel = tap_128;
      WIN_SEL_256: tap_sel = tap_256;
      default:     tap_sel = tap_1;
    endcase
  end

endmodule

// File: rtl/moving_avg_reader.sv
// Running moving average over a power-of-two window fed by the DDS tap delay line.
// Optional macro MOVING_AVG_ROUND_EN: round half-up before the output shift.
module moving_avg_reader
  import dsp_pkg::*;
#(
  parameter int SIG_WIDTH = 16,
  parameter int ACC_WIDTH = SIG_WIDTH + 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2:0]           win_sel,
  input  logic [SIG_WIDTH-1:0] x_in,
  input  logic [SIG_WIDTH-1:0] tap_1,
  input  logic [SIG_WIDTH-1:0] tap_8,
  input  logic [SIG_WIDTH-1:0] tap_16,
  input  logic [SIG_WIDTH-1:0] tap_32,
  input  logic [SIG_WIDTH-1:0] tap_64,
  input  logic [SIG_WIDTH-1:0] tap_128,
  input  logic [SIG_WIDTH-1:0] tap_256,
  output logic [SIG_WIDTH-1:0] y_out,
  output logic                 y_valid,
  output logic                 filled
);

  logic [0:0]                  state_r, state_next_s;
  logic [2:0]                  sel_q_r, sel_use_s;
  logic [8:0]                  fill_cnt_r, fill_cnt_next_s;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_next_s, x_ext_s, tap_ext_s;
  logic signed [ACC_WIDTH-1:0] round_s, y_wide_s;
  logic [SIG_WIDTH-1:0]        tap_sel_s, y_out_r;
  logic                        y_valid_r, filled_r, change_s;
  logic [3:0]                  shift_s;

  tap_mux #(.SIG_WIDTH(SIG_WIDTH)) u_tap_mux (
    .sel     (sel_q_r),
    .tap_1   (tap_1),
    .tap_8   (tap_8),
    .tap_16  (tap_16),
    .tap_32  (tap_32),
    .tap_64  (tap_64),
    .tap_128 (tap_128),
    .tap_256 (tap_256),
    .tap_sel (tap_sel_s)
  );

  // Next-state, fill counter and recursive accumulator update
  always_comb begin
    x_ext_s         = {{(ACC_WIDTH-SIG_WIDTH){x_in[SIG_WIDTH-1]}}, x_in};
    tap_ext_s       = {{(ACC_WIDTH-SIG_WIDTH){tap_sel_s[SIG_WIDTH-1]}}, tap_sel_s};
    change_s        = en && (win_sel != sel_q_r);
    sel_use_s       = change_s ? win_sel : sel_q_r;
    acc_next_s      = acc_r;
    fill_cnt_next_s = fill_cnt_r;
    state_next_s    = state_r;
    if (!en) begin
      state_next_s = state_r;
    end else if (change_s) begin
      // Restart the window from the current sample; N=1 is full at once.
      acc_next_s      = x_ext_s;
      fill_cnt_next_s = 9'd1;
      state_next_s    = (win_log2(win_sel) == 4'd0) ? ST_RUN : ST_FILL;
    end else if (state_r == ST_FILL) begin
      acc_next_s      = acc_r + x_ext_s;
      fill_cnt_next_s = fill_cnt_r + 9'd1;
      if (fill_cnt_r == win_len(sel_q_r) - 9'd1) begin
        state_next_s = ST_RUN;
      end else begin
        state_next_s = ST_FILL;
      end
    end else begin
      acc_next_s = acc_r + x_ext_s - tap_ext_s;
    end
  end

  // Output scaling: divide by N with optional half-up rounding
  always_comb begin
    shift_s = win_log2(sel_use_s);
`ifdef MOVING_AVG_ROUND_EN
    if (shift_s == 4'd0) begin
      round_s = {ACC_WIDTH{1'b0}};
    end else begin
      round_s = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (shift_s - 4'd1);
    end
`else
    round_s = {ACC_WIDTH{1'b0}};
`endif
    y_wide_s = (acc_next_s + round_s) >>> shift_s;
  end

  // State, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FILL;
      sel_q_r    <= WIN_SEL_1;
      fill_cnt_r <= 9'd0;
      acc_r      <= {ACC_WIDTH{1'b0}};
      y_out_r    <= {SIG_WIDTH{1'b0}};
      y_valid_r  <= 1'b0;
      filled_r   <= 1'b0;
    end else begin
      y_valid_r <= en;
      if (en) begin
        state_r    <= state_next_s;
        sel_q_r    <= sel_use_s;
        fill_cnt_r <= fill_cnt_next_s;
        acc_r      <= acc_next_s;
        y_out_r    <= y_wide_s[SIG_WIDTH-1:0];
        filled_r   <= (state_next_s == ST_RUN);
      end else begin
        state_r    <= state_r;
        sel_q_r    <= sel_q_r;
        fill_cnt_r <= fill_cnt_r;
        acc_r      <= acc_r;
        y_out_r    <= y_out_r;
        filled_r   <= filled_r;
      end
    end
  end

  assign y_out   = y_out_r;
  assign y_valid = y_valid_r;
  assign filled  = filled_r;

endmodule

// File: tb/tb_moving_avg_reader.sv
// Self-checking bench for moving_avg_reader: behavioural delay line plus a direct-sum reference.
module tb_moving_avg_reader;

  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n, en;
  logic [2:0]    win_sel;
  logic [SW-1:0] x_in, tap_1, tap_8, tap_16, tap_32, tap_64, tap_128, tap_256;
  logic [SW-1:0] y_out;
  logic          y_valid, filled;

  int checks = 0;
  int errors = 0;
  int hist[256];
  int exp_q[$];
  int fill_q[$];
  int m_sel, m_cnt, en_cnt, val_cnt;
  int ramp[8];
  int ramp3[8];

  moving_avg_reader dut (
    .clk(clk), .rst_n(rst_n), .en(en), .win_sel(win_sel), .x_in(x_in),
    .tap_1(tap_1), .tap_8(tap_8), .tap_16(tap_16), .tap_32(tap_32),
    .tap_64(tap_64), .tap_128(tap_128), .tap_256(tap_256),
    .y_out(y_out), .y_valid(y_valid), .filled(filled)
  );

  always #5 clk = ~clk;

  function automatic int tb_log2(input int s);
    case (s)
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 6;
      5: return 7;
      6: return 8;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 256; k++) hist[k] = 0;
    m_sel = 0;
    m_cnt = 0;
    exp_q.delete();
    fill_q.delete();
  endtask

  task automatic step(input bit e, input int ws, input int x);
    int lg, n, m;
    longint s;
    @(negedge clk);
    en      = e;
    win_sel = ws[2:0];
    x_in    = x[SW-1:0];
    tap_1   = hist[0][SW-1:0];
    tap_8   = hist[7][SW-1:0];
    tap_16  = hist[15][SW-1:0];
    tap_32  = hist[31][SW-1:0];
    tap_64  = hist[63][SW-1:0];
    tap_128 = hist[127][SW-1:0];
    tap_256 = hist[255][SW-1:0];
    if (e) begin
      en_cnt++;
      if (ws != m_sel) begin
        m_sel = ws;
        m_cnt = 1;
      end else if (m_cnt < 256) begin
        m_cnt++;
      end
      lg = tb_log2(m_sel);
      n  = 1 << lg;
      m  = (m_cnt < n) ? m_cnt : n;
      s  = x;
      for (int k = 0; k < m - 1; k++) s += hist[k];
`ifdef MOVING_AVG_ROUND_EN
      if (lg > 0) s += longint'(1) << (lg - 1);
`endif
      exp_q.push_back(int'(s >>> lg));
      fill_q.push_back((m_cnt >= n) ? 1 : 0);
    end
    @(posedge clk);
    #1;
    if (e) begin
      for (int k = 255; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
    end
    chk("y_valid", {31'd0, y_valid}, {31'd0, e});
    if (y_valid === 1'b1) begin
      val_cnt++;
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        chk("y_out", $signed(y_out), exp_q.pop_front());
        chk("filled", {31'd0, filled}, fill_q.pop_front());
      end
    end
  endtask

  initial begin
`ifdef MOVING_AVG_ROUND_EN
    ramp  = '{13, 25, 38, 50, 63, 75, 88, 100};
    ramp3 = '{0, 1, 1, 2, 2, 2, 3, 3};
`else
    ramp  = '{12, 25, 37, 50, 62, 75, 87, 100};
    ramp3 = '{0, 0, 1, 1, 1, 2, 2, 3};
`endif
    en_cnt = 0;
    val_cnt = 0;
    clear_model();
    rst_n = 1'b0; en = 1'b0; win_sel = 3'd0; x_in = '0;
    tap_1 = '0; tap_8 = '0; tap_16 = '0; tap_32 = '0;
    tap_64 = '0; tap_128 = '0; tap_256 = '0;
    repeat (2) @(negedge clk);
    chk("rst_y_out", $signed(y_out), 0);
    chk("rst_y_valid", {31'd0, y_valid}, 0);
    chk("rst_filled", {31'd0, filled}, 0);
    rst_n = 1'b1;

    // N=8 ramp with constant 100
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1, 100);
      if (i < 8) chk("ramp100", $signed(y_out), ramp[i]);
    end

    // Restart N=8 fill with constant 3
    step(1'b1, 0, 3);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1, 3);
      chk("ramp3", $signed(y_out), ramp3[i]);
    end

    // N=256 alternating +/-1000
    for (int i = 0; i < 600; i++) step(1'b1, 6, (i % 2 == 0) ? 1000 : -1000);
    chk("alt_zero", $signed(y_out), 0);

    // N=16 steady, then switch to N=1 mid-stream
    for (int i = 0; i < 20; i++) step(1'b1, 2, -32767);
    step(1'b1, 2, -32767);
    step(1'b1, 0, -32767);
    chk("sw_y_out", $signed(y_out), -32767);
    chk("sw_filled", {31'd0, filled}, 1);
    step(1'b1, 0, 1234);

    // N=32 with 30% strobe duty and random samples
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 3, int'($urandom_range(0, 65535)) - 32768);
    chk("valid_count", val_cnt, en_cnt);

    // Asynchronous reset between edges while running
    for (int i = 0; i < 5; i++) step(1'b1, 0, 500 + i);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_y_out", $signed(y_out), 0);
    chk("arst_y_valid", {31'd0, y_valid}, 0);
    chk("arst_filled", {31'd0, filled}, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1, 800);
    chk("refill_filled", {31'd0, filled}, 0);
    chk("refill_y_out", $signed(y_out), 100);
    for (int i = 0; i < 10; i++) step(1'b1, 1, int'($urandom_range(0, 2000)) - 1000);
    step(1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
